cpu_icache: RTL
===============

CPU_ICACHE -- requirements
Module: cpu_icache

Interface
REQ-001 SHALL provide parameter INDEX_BITS, default 7, giving 2^INDEX_BITS direct-mapped one-word lines.
REQ-002 SHALL have ports in this order:
- clk  in  1  the single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- en_rx  in  1  lookup request, port x.
- pcx  in  32  byte address, port x.
- en_ry  in  1  lookup request, port y.
- pcy  in  32  byte address, port y.
- hitx  out  1  port x hit.
- instx  out  32  port x word.
- hity  out  1  port y hit.
- insty  out  32  port y word.
- mem_req  out  1  byte-read request to the memory controller.
- mem_addr  out  32  byte address being requested.
- mem_ack  in  1  mem_byte is valid this cycle.
- mem_byte  in  8  returned byte.

Function
REQ-003 SHALL split each address into tag pc[31:INDEX_BITS+2], index pc[INDEX_BITS+1:2] and offset pc[1:0]; the offset SHALL be ignored because only word-aligned fetch is supported.
REQ-004 SHALL compute hitx combinationally as en_rx & valid[idx] & (tag match), with zero-cycle lookup latency; port y SHALL behave the same way.
REQ-005 SHALL pack instx as {mem[a], mem[a+1], mem[a+2], mem[a+3]}, lowest address in the MSB, because the fetch stage byte-reverses.
REQ-006 SHALL drive instx and insty to 0 when the corresponding port misses.
REQ-007 SHALL implement the refill FSM with states IDLE, FILL and WRITE.
REQ-008 IDLE -> FILL on a posedge with rdy=1 and an x miss (en_rx & ~hitx); the FSM SHALL latch the line base {pcx[31:2],2'b00} and clear the byte count.
REQ-009 FILL SHALL hold mem_req=1 and mem_addr=base+count; each mem_ack with rdy=1 SHALL store mem_byte into slot count and increment count.
REQ-010 FILL -> WRITE SHALL occur on the 4th accepted ack; mem_req SHALL drop in WRITE.
REQ-011 WRITE SHALL write data and tag, set valid[idx] and return to IDLE in one cycle; a hit on that address SHALL be visible in the first IDLE cycle.
REQ-012 Minimum miss penalty: miss sampled at edge N, acks in cycles N+1..N+4, hitx=1 in cycle N+6.
REQ-013 pcx changing during FILL SHALL NOT abort the refill; the latched line SHALL complete, and the new pcx SHALL be evaluated in IDLE.
REQ-014 When x and y both miss, x SHALL have priority; mem_ack arriving in IDLE or WRITE SHALL be ignored.
REQ-015 mem_req SHALL be 0 in IDLE and WRITE; mem_addr SHALL be don't-care when mem_req=0.
REQ-016 rdy=0 SHALL hold the state, count and arrays; mem_req SHALL keep its value, and acks SHALL NOT be counted.

Reset
REQ-017 rst low SHALL asynchronously clear all valid bits, set state=IDLE, count=0, mem_req=0 and mem_addr=0.
REQ-018 Reset during FILL SHALL discard the partial line; no valid bit SHALL be set.
REQ-019 The data and tag arrays SHALL NOT be reset.

Configuration
REQ-020 Macro ICACHE_PREFETCH_EN defined: an IDLE cycle with an x hit and a y miss (en_ry & ~hity) SHALL start a refill of pcy's line.
REQ-021 Macro ICACHE_PREFETCH_EN undefined: hity=0 and insty=0 constantly, and port y SHALL never trigger a refill.

Structure
REQ-022 word_t and addr_t SHALL come from the shared CPU defines package; the state encodings and ICACHE_LINE_BYTES=4 SHALL be added there.
REQ-023 The valid/tag/data storage with two read ports and one write port SHALL be sub-module cpu_icache_array; FSM and packing SHALL stay in cpu_icache.

Verification
REQ-024 Reset, then en_rx=1, pcx=0x0 -> hitx=0, mem_req=1, mem_addr=0x0..0x3; ack bytes 0x13,0x05,0x00,0x00 -> instx=0x13050000 with hitx=1 in cycle N+6.
REQ-025 Fill 0x0, then pcx=0x200 (same index, INDEX_BITS=7) -> miss and refill; afterwards pcx=0x0 -> miss again.
REQ-026 Assert rst low after 2 acks, then release -> mem_req=0, state IDLE, pcx=0x0 misses.
REQ-027 rdy=0 for 3 cycles mid-FILL with mem_ack=1 -> count unchanged; resume -> exactly 4 bytes stored.
REQ-028 With ICACHE_PREFETCH_EN defined: pcx=0x0 (hit), pcy=0x4 (miss) -> refill of 0x4..0x7, then hity=1; with the macro undefined -> hity stays 0 and mem_req stays 0.
REQ-029 Change pcx from 0x10 to 0x40 mid-FILL -> the 0x10 line completes, then a 0x40 refill starts.

Source files
------------

// File: rtl/cpu_icache_pkg.sv
// cpu_icache_pkg: shared CPU word/address types plus instruction-cache line size and refill states.
package cpu_icache_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  localparam int ICACHE_LINE_BYTES = 4;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} icache_state_t;
endpackage

// File: rtl/cpu_icache_array.sv
// cpu_icache_array: direct-mapped valid/tag/data storage with two combinational read ports and one write port.
module cpu_icache_array
  import cpu_icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx_x,
  input  logic [TAG_BITS-1:0]   tag_x,
  output logic                  hit_x,
  output word_t                 data_x,
  input  logic [INDEX_BITS-1:0] idx_y,
  input  logic [TAG_BITS-1:0]   tag_y,
  output logic                  hit_y,
  output word_t                 data_y,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  word_t                 wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  word_t               data [LINES];
  always_ff @(posedge clk or negedge rst)
    if (!rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  // tag and data carry no reset; valid alone qualifies them
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  assign hit_x  = valid[idx_x] && tags[idx_x] == tag_x;
  assign data_x = data[idx_x];
  assign hit_y  = valid[idx_y] && tags[idx_y] == tag_y;
  assign data_y = data[idx_y];
endmodule

// File: rtl/cpu_icache.sv
// cpu_icache: dual-lookup direct-mapped instruction cache with byte-serial refill FSM.
// Define ICACHE_PREFETCH_EN to let port y misses (while x hits) trigger refills.
module cpu_icache
  import cpu_icache_pkg::*;
#(
  parameter int INDEX_BITS = 7
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  input  logic  en_rx,
  input  addr_t pcx,
  input  logic  en_ry,
  input  addr_t pcy,
  output logic  hitx,
  output word_t instx,
  output logic  hity,
  output word_t insty,
  output logic  mem_req,
  output addr_t mem_addr,
  input  logic  mem_ack,
  input  logic  [7:0] mem_byte
);
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  icache_state_t state, nxt;
  logic [29:0] base;
  logic [1:0]  cnt;
  word_t       line;
  logic        hit_x, hit_y, miss_x, pf_y, start, last_ack;
  word_t       data_x, data_y;
  logic        unused_off;
  cpu_icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx_x   (pcx[INDEX_BITS+1:2]),
    .tag_x   (pcx[31:INDEX_BITS+2]),
    .hit_x   (hit_x),
    .data_x  (data_x),
    .idx_y   (pcy[INDEX_BITS+1:2]),
    .tag_y   (pcy[31:INDEX_BITS+2]),
    .hit_y   (hit_y),
    .data_y  (data_y),
    .we      (rdy && state == WRITE),
    .wr_idx  (base[INDEX_BITS-1:0]),
    .wr_tag  (base[29:INDEX_BITS]),
    .wr_data (line)
  );
  assign unused_off = ^{pcx[1:0], pcy[1:0]};
  assign hitx   = en_rx & hit_x;
  assign instx  = hitx ? data_x : '0;
  assign miss_x = en_rx & ~hit_x;
`ifdef ICACHE_PREFETCH_EN
  assign hity  = en_ry & hit_y;
  assign insty = hity ? data_y : '0;
  assign pf_y  = hitx & en_ry & ~hit_y;
`else
  logic unused_y;
  assign unused_y = ^{en_ry, hit_y, data_y};
  assign hity  = 1'b0;
  assign insty = '0;
  assign pf_y  = 1'b0;
`endif
  assign start    = state == IDLE && (miss_x | pf_y);
  assign last_ack = state == FILL && mem_ack && cnt == 2'(ICACHE_LINE_BYTES - 1);
  assign mem_req  = state == FILL;
  assign mem_addr = {base, cnt};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (rdy) nxt = start ? FILL : last_ack ? WRITE : state == WRITE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      base <= '0;
      cnt  <= '0;
    end else if (rdy) begin
      if (start) begin
        base <= miss_x ? pcx[31:2] : pcy[31:2];
        cnt  <= '0;
      end else if (state == FILL && mem_ack) cnt <= cnt + 2'd1;
    end
  // first byte shifts up to the MSB after four acks
  always_ff @(posedge clk)
    if (rdy && state == FILL && mem_ack) line <= {line[23:0], mem_byte};
endmodule
